// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - integer ALU reservation station with CDB snoop and writeback
module alu_rs #(
  parameter int DEPTH       = 4,
  parameter int XLEN        = 64,
  parameter int ROB_IDX_LEN = 6,
  parameter int EU_CTL_LEN  = 4,
  parameter int EXCEPT_LEN  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   issue_valid_i,
  output logic                   issue_ready_o,
  input  logic [EU_CTL_LEN-1:0]  issue_eu_ctl_i,
  input  logic                   issue_rs1_ready_i,
  input  logic [ROB_IDX_LEN-1:0] issue_rs1_idx_i,
  input  logic [XLEN-1:0]        issue_rs1_value_i,
  input  logic                   issue_rs2_ready_i,
  input  logic [ROB_IDX_LEN-1:0] issue_rs2_idx_i,
  input  logic [XLEN-1:0]        issue_rs2_value_i,
  input  logic [ROB_IDX_LEN-1:0] issue_rob_idx_i,
  output logic                   eu_valid_o,
  input  logic                   eu_ready_i,
  output logic [EU_CTL_LEN-1:0]  eu_ctl_o,
  output logic [XLEN-1:0]        eu_rs1_o,
  output logic [XLEN-1:0]        eu_rs2_o,
  output logic [ROB_IDX_LEN-1:0] eu_rob_idx_o,
  input  logic                   eu_valid_i,
  output logic                   eu_ready_o,
  input  logic [ROB_IDX_LEN-1:0] eu_rob_idx_i,
  input  logic [XLEN-1:0]        eu_result_i,
  input  logic                   eu_except_raised_i,
  input  logic [EXCEPT_LEN-1:0]  eu_except_code_i,
  input  logic                   cdb_valid_i,
  input  logic [ROB_IDX_LEN-1:0] cdb_rob_idx_i,
  input  logic [XLEN-1:0]        cdb_value_i,
  output logic                   cdb_valid_o,
  input  logic                   cdb_ready_i,
  output logic [ROB_IDX_LEN-1:0] cdb_rob_idx_o,
  output logic [XLEN-1:0]        cdb_value_o,
  output logic                   cdb_except_raised_o,
  output logic [EXCEPT_LEN-1:0]  cdb_except_code_o
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] S_EMPTY = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_READY = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  typedef struct packed {
    logic [EU_CTL_LEN-1:0]  ctl;
    logic                   rdy1;
    logic [ROB_IDX_LEN-1:0] tag1;
    logic [XLEN-1:0]        val1;
    logic                   rdy2;
    logic [ROB_IDX_LEN-1:0] tag2;
    logic [XLEN-1:0]        val2;
    logic [ROB_IDX_LEN-1:0] rob;
    logic [XLEN-1:0]        res;
    logic                   exc;
    logic [EXCEPT_LEN-1:0]  code;
  } entry_t;

  logic [2:0] st   [DEPTH];
  logic [2:0] st_n [DEPTH];
  entry_t     ent  [DEPTH];
  entry_t     ent_n[DEPTH];

  logic          alloc_any, disp_any, wb_any;
  logic [IW-1:0] alloc_idx, disp_idx, wb_idx;
  logic          alloc_fire;
  logic          fwd1, fwd2;
  logic [XLEN-1:0] fval1, fval2;

  // Lowest-index EMPTY / READY / DONE pickers, all from registered state
  always_comb begin
    alloc_any = 1'b0;
    alloc_idx = '0;
    disp_any  = 1'b0;
    disp_idx  = '0;
    wb_any    = 1'b0;
    wb_idx    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (st[i] == S_EMPTY) begin
        alloc_any = 1'b1;
        alloc_idx = IW'(i);
      end
      if (st[i] == S_READY) begin
        disp_any = 1'b1;
        disp_idx = IW'(i);
      end
      if (st[i] == S_DONE) begin
        wb_any = 1'b1;
        wb_idx = IW'(i);
      end
    end
  end

  // Issuing operands may be satisfied by the broadcast happening this same cycle
  always_comb begin
    alloc_fire = issue_valid_i && alloc_any;
    fwd1  = issue_rs1_ready_i || (cdb_valid_i && (cdb_rob_idx_i == issue_rs1_idx_i));
    fwd2  = issue_rs2_ready_i || (cdb_valid_i && (cdb_rob_idx_i == issue_rs2_idx_i));
    fval1 = issue_rs1_ready_i ? issue_rs1_value_i : cdb_value_i;
    fval2 = issue_rs2_ready_i ? issue_rs2_value_i : cdb_value_i;
  end

  // Per-entry next state: allocate, snoop, dispatch, complete, writeback
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      st_n[i]  = st[i];
      ent_n[i] = ent[i];
      case (st[i])
        S_EMPTY: begin
          if (alloc_fire && (alloc_idx == IW'(i))) begin
            ent_n[i].ctl  = issue_eu_ctl_i;
            ent_n[i].rdy1 = fwd1;
            ent_n[i].tag1 = issue_rs1_idx_i;
            ent_n[i].val1 = fval1;
            ent_n[i].rdy2 = fwd2;
            ent_n[i].tag2 = issue_rs2_idx_i;
            ent_n[i].val2 = fval2;
            ent_n[i].rob  = issue_rob_idx_i;
            st_n[i] = (fwd1 && fwd2) ? S_READY : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cdb_valid_i && !ent[i].rdy1 && (ent[i].tag1 == cdb_rob_idx_i)) begin
            ent_n[i].rdy1 = 1'b1;
            ent_n[i].val1 = cdb_value_i;
          end
          if (cdb_valid_i && !ent[i].rdy2 && (ent[i].tag2 == cdb_rob_idx_i)) begin
            ent_n[i].rdy2 = 1'b1;
            ent_n[i].val2 = cdb_value_i;
          end
          if (ent_n[i].rdy1 && ent_n[i].rdy2) begin
            st_n[i] = S_READY;
          end
        end
        S_READY: begin
          if (eu_ready_i && (disp_idx == IW'(i))) begin
            st_n[i] = S_EXEC;
          end
        end
        S_EXEC: begin
          if (eu_valid_i && (ent[i].rob == eu_rob_idx_i)) begin
            ent_n[i].res  = eu_result_i;
            ent_n[i].exc  = eu_except_raised_i;
            ent_n[i].code = eu_except_code_i;
            st_n[i] = S_DONE;
          end
        end
        S_DONE: begin
          if (cdb_ready_i && (wb_idx == IW'(i))) begin
            st_n[i] = S_EMPTY;
          end
        end
        default: st_n[i] = S_EMPTY;
      endcase
    end
  end

  // Entry state register; reset and flush both squash everything
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst_i || flush_i) begin
        st[i] <= S_EMPTY;
      end else begin
        st[i] <= st_n[i];
      end
    end
  end

  // Entry payload register; contents are meaningless while EMPTY
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      ent[i] <= ent_n[i];
    end
  end

  // Outputs: data buses forced to zero whenever their valid is low
  always_comb begin
    issue_ready_o       = alloc_any;
    eu_ready_o          = 1'b1;
    eu_valid_o          = disp_any;
    eu_ctl_o            = disp_any ? ent[disp_idx].ctl  : '0;
    eu_rs1_o            = disp_any ? ent[disp_idx].val1 : '0;
    eu_rs2_o            = disp_any ? ent[disp_idx].val2 : '0;
    eu_rob_idx_o        = disp_any ? ent[disp_idx].rob  : '0;
    cdb_valid_o         = wb_any;
    cdb_rob_idx_o       = wb_any ? ent[wb_idx].rob  : '0;
    cdb_value_o         = wb_any ? ent[wb_idx].res  : '0;
    cdb_except_raised_o = wb_any ? ent[wb_idx].exc  : 1'b0;
    cdb_except_code_o   = wb_any ? ent[wb_idx].code : '0;
  end

endmodule
